// File: rtl/cache_mem_arbiter.sv
// N-channel line-fill arbiter in front of a single-ported main memory.
// One burst of BEATS words per grant, fixed-priority or round-robin selection.
module cache_mem_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 16,
    parameter int BEATS   = 4,
    parameter int RR_MODE = 0,
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH*ADDR_W-1:0] addr,
    input  logic                     mem_ready,
    output logic [NUM_CH-1:0]        grant,
    output logic [NUM_CH-1:0]        stall,
    output logic [NUM_CH-1:0]        done,
    output logic                     mem_request,
    output logic [ADDR_W-1:0]        mem_address_out,
    output logic [BEAT_W-1:0]        mem_beat
);

    localparam int CH_W = $clog2(NUM_CH);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(BEATS - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    logic [0:0]        state_reg;
    logic [NUM_CH-1:0] grant_reg;
    logic [NUM_CH-1:0] done_reg;
    logic              mem_request_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [ADDR_W-1:0] addr_out_reg;
    logic [BEAT_W-1:0] beat_reg;
    logic [CH_W-1:0]   last_reg;

    logic [ADDR_W-1:0] addr_ch [NUM_CH];
    logic              win_found;
    logic [CH_W-1:0]   win_idx;
    logic [CH_W-1:0]   cand_idx;
    logic [ADDR_W-1:0] win_base;
    logic [BEAT_W-1:0] beat_next;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_addr_split
            assign addr_ch[gi] = addr[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    // Scan starts at channel 0 (fixed) or just past the previous winner (round-robin).
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (RR_MODE != 0) begin
                cand_idx = CH_W'((int'(last_reg) + 1 + k) % NUM_CH);
            end else begin
                cand_idx = CH_W'(k);
            end
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    assign win_base  = addr_ch[win_idx] & LINE_MASK;
    assign beat_next = beat_reg + BEAT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            grant_reg       <= '0;
            done_reg        <= '0;
            mem_request_reg <= 1'b0;
            base_reg        <= '0;
            addr_out_reg    <= '0;
            beat_reg        <= '0;
            last_reg        <= CH_W'(NUM_CH - 1);
        end else begin
            done_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        state_reg       <= BUSY;
                        grant_reg       <= NUM_CH'(1) << win_idx;
                        mem_request_reg <= 1'b1;
                        base_reg        <= win_base;
                        addr_out_reg    <= win_base;
                        beat_reg        <= '0;
                        last_reg        <= win_idx;
                    end
                end
                default: begin
                    if (mem_ready) begin
                        if (beat_reg == LAST_BEAT) begin
                            state_reg       <= IDLE;
                            grant_reg       <= '0;
                            mem_request_reg <= 1'b0;
                            beat_reg        <= '0;
                            done_reg        <= grant_reg;
                        end else begin
                            // Offset only fills the cleared low bits, so no carry into the tag.
                            beat_reg     <= beat_next;
                            addr_out_reg <= base_reg | ADDR_W'(beat_next);
                        end
                    end
                end
            endcase
        end
    end

    assign grant           = grant_reg;
    assign done            = done_reg;
    assign mem_request     = mem_request_reg;
    assign mem_address_out = addr_out_reg;
    assign mem_beat        = beat_reg;
    assign stall           = (state_reg == BUSY) ? (req & ~grant_reg) : '0;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: three instances cover fixed priority,
// round-robin over four channels, and single-beat lines with a 12-bit address.
module tb_cache_mem_arbiter;

    typedef struct packed {
        logic [3:0]  g;
        logic [15:0] a;
        logic [1:0]  b;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: 2 channels, 16-bit, 4 beats, fixed priority
    logic [1:0]  req_a, grant_a, stall_a, done_a;
    logic [31:0] addr_a;
    logic        rdy_a, mreq_a;
    logic [15:0] maddr_a;
    logic [1:0]  mbeat_a;
    // Instance B: 4 channels, round-robin
    logic [3:0]  req_b, grant_b, stall_b, done_b;
    logic [63:0] addr_b;
    logic        rdy_b, mreq_b;
    logic [15:0] maddr_b;
    logic [1:0]  mbeat_b;
    // Instance C: 2 channels, 12-bit, single-beat lines
    logic [1:0]  req_c, grant_c, stall_c, done_c;
    logic [23:0] addr_c;
    logic        rdy_c, mreq_c;
    logic [11:0] maddr_c;
    logic [0:0]  mbeat_c;

    cache_mem_arbiter #(.NUM_CH(2), .ADDR_W(16), .BEATS(4), .RR_MODE(0)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .addr(addr_a), .mem_ready(rdy_a),
        .grant(grant_a), .stall(stall_a), .done(done_a), .mem_request(mreq_a),
        .mem_address_out(maddr_a), .mem_beat(mbeat_a));

    cache_mem_arbiter #(.NUM_CH(4), .ADDR_W(16), .BEATS(4), .RR_MODE(1)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .addr(addr_b), .mem_ready(rdy_b),
        .grant(grant_b), .stall(stall_b), .done(done_b), .mem_request(mreq_b),
        .mem_address_out(maddr_b), .mem_beat(mbeat_b));

    cache_mem_arbiter #(.NUM_CH(2), .ADDR_W(12), .BEATS(1), .RR_MODE(0)) dut_c (
        .clk(clk), .rst(rst), .req(req_c), .addr(addr_c), .mem_ready(rdy_c),
        .grant(grant_c), .stall(stall_c), .done(done_c), .mem_request(mreq_c),
        .mem_address_out(maddr_c), .mem_beat(mbeat_c));

    beat_t      q_a[$], q_b[$], q_c[$];
    logic [3:0] dq_a[$], dq_b[$], dq_c[$];
    int         n_cmp = 0;
    int         n_err = 0;

    // Beat consumers: a beat transfers on the edge where mem_request and mem_ready are both high.
    beat_t act_a, exp_a, act_b, exp_b, act_c, exp_c;
    logic [3:0] dexp_a, dexp_b, dexp_c;

    always @(negedge clk) begin
        #1;
        if (!rst && mreq_a && rdy_a) begin
            act_a = '{g:{2'b00, grant_a}, a:maddr_a, b:mbeat_a};
            n_cmp++;
            if (q_a.size() == 0) begin
                n_err++; $display("FAIL beat_a: got g=%b a=%h b=%0d, expected no beat", act_a.g, act_a.a, act_a.b);
            end else begin
                exp_a = q_a.pop_front();
                if (act_a !== exp_a) begin
                    n_err++;
                    $display("FAIL beat_a: got g=%b a=%h b=%0d, expected g=%b a=%h b=%0d",
                             act_a.g, act_a.a, act_a.b, exp_a.g, exp_a.a, exp_a.b);
                end else $display("beat_a g=%b a=%h b=%0d", act_a.g, act_a.a, act_a.b);
            end
        end
        if (!rst && done_a !== 2'b00) begin
            n_cmp++;
            if (dq_a.size() == 0) begin
                n_err++; $display("FAIL done_a: got %b, expected none", done_a);
            end else begin
                dexp_a = dq_a.pop_front();
                if ({2'b00, done_a} !== dexp_a) begin
                    n_err++; $display("FAIL done_a: got %b, expected %b", done_a, dexp_a[1:0]);
                end else $display("done_a %b", done_a);
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (!rst && mreq_b && rdy_b) begin
            act_b = '{g:grant_b, a:maddr_b, b:mbeat_b};
            n_cmp++;
            if (q_b.size() == 0) begin
                n_err++; $display("FAIL beat_b: got g=%b a=%h b=%0d, expected no beat", act_b.g, act_b.a, act_b.b);
            end else begin
                exp_b = q_b.pop_front();
                if (act_b !== exp_b) begin
                    n_err++;
                    $display("FAIL beat_b: got g=%b a=%h b=%0d, expected g=%b a=%h b=%0d",
                             act_b.g, act_b.a, act_b.b, exp_b.g, exp_b.a, exp_b.b);
                end else $display("beat_b g=%b a=%h b=%0d", act_b.g, act_b.a, act_b.b);
            end
        end
        if (!rst && done_b !== 4'b0000) begin
            n_cmp++;
            if (dq_b.size() == 0) begin
                n_err++; $display("FAIL done_b: got %b, expected none", done_b);
            end else begin
                dexp_b = dq_b.pop_front();
                if (done_b !== dexp_b) begin
                    n_err++; $display("FAIL done_b: got %b, expected %b", done_b, dexp_b);
                end else $display("done_b %b", done_b);
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (!rst && mreq_c && rdy_c) begin
            act_c = '{g:{2'b00, grant_c}, a:{4'h0, maddr_c}, b:{1'b0, mbeat_c}};
            n_cmp++;
            if (q_c.size() == 0) begin
                n_err++; $display("FAIL beat_c: got g=%b a=%h b=%0d, expected no beat", act_c.g, act_c.a, act_c.b);
            end else begin
                exp_c = q_c.pop_front();
                if (act_c !== exp_c) begin
                    n_err++;
                    $display("FAIL beat_c: got g=%b a=%h b=%0d, expected g=%b a=%h b=%0d",
                             act_c.g, act_c.a, act_c.b, exp_c.g, exp_c.a, exp_c.b);
                end else $display("beat_c g=%b a=%h b=%0d", act_c.g, act_c.a, act_c.b);
            end
        end
        if (!rst && done_c !== 2'b00) begin
            n_cmp++;
            if (dq_c.size() == 0) begin
                n_err++; $display("FAIL done_c: got %b, expected none", done_c);
            end else begin
                dexp_c = dq_c.pop_front();
                if ({2'b00, done_c} !== dexp_c) begin
                    n_err++; $display("FAIL done_c: got %b, expected %b", done_c, dexp_c[1:0]);
                end else $display("done_c %b", done_c);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req_a = 2'($urandom); addr_a = $urandom; rdy_a = 1'($urandom);
            req_b = 4'($urandom); addr_b = {$urandom, $urandom}; rdy_b = 1'($urandom);
            req_c = 2'($urandom); addr_c = 24'($urandom); rdy_c = 1'($urandom);
        end
        @(negedge clk);
        #1;
        n_cmp++; if (grant_a !== 2'b00) begin n_err++; $display("FAIL rst_grant_a: got %b, expected 00", grant_a); end
        n_cmp++; if (mreq_a !== 1'b0) begin n_err++; $display("FAIL rst_mreq_a: got %b, expected 0", mreq_a); end
        n_cmp++; if (maddr_a !== 16'h0) begin n_err++; $display("FAIL rst_addr_a: got %h, expected 0000", maddr_a); end
        n_cmp++; if (mbeat_a !== 2'd0) begin n_err++; $display("FAIL rst_beat_a: got %0d, expected 0", mbeat_a); end
        n_cmp++; if (done_a !== 2'b00) begin n_err++; $display("FAIL rst_done_a: got %b, expected 00", done_a); end
        n_cmp++; if (stall_a !== 2'b00) begin n_err++; $display("FAIL rst_stall_a: got %b, expected 00", stall_a); end
        n_cmp++; if ({grant_b, stall_b, mreq_b} !== 9'd0) begin n_err++; $display("FAIL rst_b: got g=%b s=%b r=%b, expected zeros", grant_b, stall_b, mreq_b); end
        n_cmp++; if ({grant_c, stall_c, mreq_c} !== 5'd0) begin n_err++; $display("FAIL rst_c: got g=%b s=%b r=%b, expected zeros", grant_c, stall_c, mreq_c); end
        req_a = '0; rdy_a = 1'b0; req_b = '0; rdy_b = 1'b0; req_c = '0; rdy_c = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_burst();
        int  cnt = 0;
        bit  seen = 0;
        for (int i = 0; i < 4; i++) q_a.push_back('{g:4'b0010, a:16'h1234 + 16'(i), b:2'(i)});
        dq_a.push_back(4'b0010);
        @(negedge clk);
        req_a = 2'b10; addr_a = {16'h1237, 16'h0000}; rdy_a = 1'b1;
        for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
            @(negedge clk);
            if (mreq_a) begin cnt++; req_a = 2'b00; end
            if (done_a !== 2'b00) begin
                seen = 1;
                n_cmp++;
                if (grant_a !== 2'b00 || mreq_a !== 1'b0) begin
                    n_err++; $display("FAIL single_done_cycle: got grant=%b mreq=%b, expected 00/0", grant_a, mreq_a);
                end
            end
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL single_timeout: got no done, expected done"); end
        n_cmp++; if (cnt != 4) begin n_err++; $display("FAIL single_len: got %0d mreq cycles, expected 4", cnt); end
        rdy_a = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fixed_priority();
        int dones = 0;
        int last_cyc = 0;
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 4; i++) q_a.push_back('{g:4'b0001, a:16'h0040 + 16'(i), b:2'(i)});
            dq_a.push_back(4'b0001);
        end
        @(negedge clk);
        req_a = 2'b11; addr_a = {16'h0F00, 16'h0043}; rdy_a = 1'b1;
        for (int cyc = 0; cyc < 40 && dones < 3; cyc++) begin
            @(negedge clk);
            if (mreq_a) begin
                n_cmp++;
                if (stall_a !== 2'b10) begin n_err++; $display("FAIL fixed_stall: got %b, expected 10", stall_a); end
            end
            if (done_a !== 2'b00) begin
                dones++;
                n_cmp++;
                if (stall_a !== 2'b00) begin n_err++; $display("FAIL fixed_idle_stall: got %b, expected 00", stall_a); end
                if (dones > 1) begin
                    n_cmp++;
                    if (cyc - last_cyc != 5) begin n_err++; $display("FAIL fixed_gap: got %0d cycles per line, expected 5", cyc - last_cyc); end
                end
                last_cyc = cyc;
                if (dones == 3) req_a = 2'b00;
            end
        end
        n_cmp++; if (dones != 3) begin n_err++; $display("FAIL fixed_timeout: got %0d dones, expected 3", dones); end
        rdy_a = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wait_states();
        bit pat[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        int r = 0;
        int w = 0;
        for (int i = 0; i < 4; i++) q_a.push_back('{g:4'b0001, a:16'h2220 + 16'(i), b:2'(i)});
        dq_a.push_back(4'b0001);
        @(negedge clk);
        req_a = 2'b01; addr_a = {16'h0000, 16'h2222}; rdy_a = 1'b0;
        while (!mreq_a && w < 5) begin @(negedge clk); w++; end
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            req_a = 2'b00;
            n_cmp++;
            if ({mreq_a, maddr_a, mbeat_a} !== {1'b1, 16'h2220 + 16'(r), 2'(r)}) begin
                n_err++;
                $display("FAIL wait_hold: got mreq=%b a=%h b=%0d, expected 1 a=%h b=%0d",
                         mreq_a, maddr_a, mbeat_a, 16'h2220 + 16'(r), r);
            end
            rdy_a = pat[i];
            if (pat[i]) r++;
        end
        @(negedge clk);
        rdy_a = 1'b0;
        n_cmp++;
        if (done_a !== 2'b01) begin n_err++; $display("FAIL wait_done: got %b, expected 01", done_a); end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int g_seq[8] = '{0, 1, 2, 3, 0, 1, 2, 0};
        int nb = 0;
        logic [3:0] exp_stall;
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 4; i++)
                q_b.push_back('{g:4'(1 << g_seq[n]), a:((16'h1001 * 16'(g_seq[n] + 1)) & 16'hFFFC) + 16'(i), b:2'(i)});
            dq_b.push_back(4'(1 << g_seq[n]));
        end
        @(negedge clk);
        req_b = 4'b1111; addr_b = {16'h4004, 16'h3003, 16'h2002, 16'h1001}; rdy_b = 1'b1;
        for (int cyc = 0; cyc < 80 && nb < 8; cyc++) begin
            @(negedge clk);
            if (mreq_b) begin
                exp_stall = req_b & ~4'(1 << g_seq[nb]);
                n_cmp++;
                if (stall_b !== exp_stall) begin n_err++; $display("FAIL rr_stall: got %b, expected %b", stall_b, exp_stall); end
            end
            if (done_b !== 4'b0000) begin
                nb++;
                if (nb == 6) req_b = 4'b0101;
                if (nb == 8) req_b = 4'b0000;
            end
        end
        n_cmp++; if (nb != 8) begin n_err++; $display("FAIL rr_timeout: got %0d bursts, expected 8", nb); end
        rdy_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_requester_drop();
        int  cnt = 0;
        bit  seen = 0;
        for (int i = 0; i < 4; i++) q_a.push_back('{g:4'b0001, a:16'h0ABC + 16'(i), b:2'(i)});
        dq_a.push_back(4'b0001);
        @(negedge clk);
        req_a = 2'b01; addr_a = {16'h0000, 16'h0ABE}; rdy_a = 1'b1;
        for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
            @(negedge clk);
            if (mreq_a) cnt++;
            if (mreq_a && mbeat_a == 2'd1) req_a = 2'b00;
            if (done_a !== 2'b00) seen = 1;
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL drop_timeout: got no done, expected done"); end
        n_cmp++; if (cnt != 4) begin n_err++; $display("FAIL drop_len: got %0d beats, expected 4", cnt); end
        rdy_a = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_beats1();
        int cnt = 0;
        int dones = 0;
        q_c.push_back('{g:4'b0001, a:16'h0123, b:2'd0});
        q_c.push_back('{g:4'b0010, a:16'h0ABD, b:2'd0});
        dq_c.push_back(4'b0001);
        dq_c.push_back(4'b0010);
        @(negedge clk);
        req_c = 2'b11; addr_c = {12'hABD, 12'h123}; rdy_c = 1'b1;
        for (int cyc = 0; cyc < 20 && dones < 2; cyc++) begin
            @(negedge clk);
            if (mreq_c) begin
                cnt++;
                req_c = req_c & ~grant_c;
                n_cmp++;
                if (mbeat_c !== 1'b0) begin n_err++; $display("FAIL b1_beat: got %0d, expected 0", mbeat_c); end
            end
            if (done_c !== 2'b00) dones++;
        end
        n_cmp++; if (cnt != 2 || dones != 2) begin n_err++; $display("FAIL b1_len: got %0d beats %0d dones, expected 2 2", cnt, dones); end
        rdy_c = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_midburst();
        int w = 0;
        for (int i = 0; i < 3; i++) q_a.push_back('{g:4'b0001, a:16'h0300 + 16'(i), b:2'(i)});
        @(negedge clk);
        req_a = 2'b01; addr_a = {16'h0000, 16'h0301}; rdy_a = 1'b1;
        while (!(mreq_a && mbeat_a == 2'd2) && w < 20) begin @(negedge clk); w++; end
        n_cmp++; if (w >= 20) begin n_err++; $display("FAIL mid_timeout: got no beat 2, expected beat 2"); end
        req_a = 2'b00;
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (grant_a !== 2'b00) begin n_err++; $display("FAIL mid_grant: got %b, expected 00", grant_a); end
        n_cmp++; if (mreq_a !== 1'b0) begin n_err++; $display("FAIL mid_mreq: got %b, expected 0", mreq_a); end
        n_cmp++; if (mbeat_a !== 2'd0) begin n_err++; $display("FAIL mid_beat: got %0d, expected 0", mbeat_a); end
        n_cmp++; if (maddr_a !== 16'h0) begin n_err++; $display("FAIL mid_addr: got %h, expected 0000", maddr_a); end
        n_cmp++; if (stall_a !== 2'b00) begin n_err++; $display("FAIL mid_stall: got %b, expected 00", stall_a); end
        @(negedge clk);
        rst = 1'b0;
        rdy_a = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        req_a = '0; addr_a = '0; rdy_a = 1'b0;
        req_b = '0; addr_b = '0; rdy_b = 1'b0;
        req_c = '0; addr_c = '0; rdy_c = 1'b0;
        test_reset();
        test_single_burst();
        test_fixed_priority();
        test_wait_states();
        test_round_robin();
        test_requester_drop();
        test_beats1();
        test_reset_midburst();
        @(negedge clk);
        n_cmp++;
        if (q_a.size() + q_b.size() + q_c.size() + dq_a.size() + dq_b.size() + dq_c.size() != 0) begin
            n_err++;
            $display("FAIL leftover: got %0d/%0d/%0d beats %0d/%0d/%0d dones pending, expected 0",
                     q_a.size(), q_b.size(), q_c.size(), dq_a.size(), dq_b.size(), dq_c.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
